// File: rtl/mc_ctrl.sv
// Multi-cycle RISC-V main controller: FETCH/DECODE/EXEC/MEM/WB sequencing, trap and retire count.
// Optional MC_MEM_WAIT_EN makes FETCH and MEM stall until mem_ready.
module mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  Op,
  input  logic [6:0]  Funct7,
  input  logic [2:0]  Funct3,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [5:0]  EXTOp,
  output logic [4:0]  ALUOp,
  output logic        ALUSrc,
  output logic [2:0]  DMType,
  output logic [1:0]  WDSel,
  output logic [2:0]  NPCOp,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam int unsigned CNT_W = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [5:0] EXT_J = 6'b000001;
  localparam logic [5:0] EXT_U = 6'b000010;
  localparam logic [5:0] EXT_B = 6'b000100;
  localparam logic [5:0] EXT_S = 6'b001000;
  localparam logic [5:0] EXT_I = 6'b010000;

  localparam logic [4:0] ALU_NOP   = 5'd0;
  localparam logic [4:0] ALU_LUI   = 5'd1;
  localparam logic [4:0] ALU_AUIPC = 5'd2;
  localparam logic [4:0] ALU_ADD   = 5'd3;
  localparam logic [4:0] ALU_SUB   = 5'd4;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  state_t cur, nxt;
  logic   rdy;
  logic   legal;
  logic [5:0] ext_sel;
  logic [4:0] alu_sel;
  logic       imm_sel;

`ifdef MC_MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign rdy = 1'b1;
`endif

  assign state = cur;

  // Opcode class decode: legality, immediate format, ALU operation, operand B select
  always_comb begin
    legal   = 1'b1;
    ext_sel = 6'b000000;
    alu_sel = ALU_NOP;
    imm_sel = 1'b0;
    case (Op)
      OPC_LUI:    begin ext_sel = EXT_U; alu_sel = ALU_LUI;   imm_sel = 1'b1; end
      OPC_AUIPC:  begin ext_sel = EXT_U; alu_sel = ALU_AUIPC; imm_sel = 1'b1; end
      OPC_JAL:    begin ext_sel = EXT_J; end
      OPC_JALR:   begin ext_sel = EXT_I; alu_sel = ALU_ADD;   imm_sel = 1'b1; end
      OPC_BRANCH: begin ext_sel = EXT_B; alu_sel = ALU_SUB; end
      OPC_LOAD:   begin ext_sel = EXT_I; alu_sel = ALU_ADD;   imm_sel = 1'b1; end
      OPC_STORE:  begin ext_sel = EXT_S; alu_sel = ALU_ADD;   imm_sel = 1'b1; end
      OPC_OPIMM: begin
        ext_sel = EXT_I;
        imm_sel = 1'b1;
        alu_sel = (Funct3 == 3'b000) ? ALU_ADD : ALU_NOP;
      end
      OPC_OP: begin
        if (Funct7 == F7_ALT)                             alu_sel = ALU_SUB;
        else if (Funct7 == F7_BASE && Funct3 == 3'b000)   alu_sel = ALU_ADD;
        else                                              alu_sel = ALU_NOP;
      end
      default: legal = 1'b0;
    endcase
  end

  // Next state and per-state control outputs
  always_comb begin
    nxt      = cur;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    EXTOp    = 6'b000000;
    ALUOp    = ALU_NOP;
    ALUSrc   = 1'b0;
    DMType   = 3'b000;
    WDSel    = 2'b00;
    NPCOp    = 3'b000;
    case (cur)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = rdy;
        if (rdy) nxt = DECODE;
      end
      DECODE: begin
        EXTOp = ext_sel;
        nxt   = legal ? EXEC : TRAP;
      end
      EXEC: begin
        EXTOp  = ext_sel;
        ALUOp  = alu_sel;
        ALUSrc = imm_sel;
        if (!legal) begin
          nxt = TRAP;
        end else if (Op == OPC_LOAD || Op == OPC_STORE) begin
          nxt = MEM;
        end else if (Op == OPC_BRANCH) begin
          PCWrite = 1'b1;
          NPCOp   = (Funct3 == 3'b000 && Zero) ? 3'b001 : 3'b000;
          nxt     = FETCH;
        end else begin
          nxt = WB;
        end
      end
      MEM: begin
        ALUSrc = 1'b1;
        ALUOp  = ALU_ADD;
        DMType = Funct3;
        if (Op == OPC_LOAD) begin
          MemRead = 1'b1;
          if (rdy) nxt = WB;
        end else if (Op == OPC_STORE) begin
          MemWrite = 1'b1;
          PCWrite  = rdy;
          if (rdy) nxt = FETCH;
        end else begin
          nxt = FETCH;
        end
      end
      WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        nxt      = FETCH;
        if (Op == OPC_LOAD) begin
          WDSel = 2'b01;
        end else if (Op == OPC_JAL) begin
          WDSel = 2'b10;
          NPCOp = 3'b010;
        end else if (Op == OPC_JALR) begin
          WDSel  = 2'b10;
          NPCOp  = 3'b100;
          ALUSrc = 1'b1;
          ALUOp  = ALU_ADD;
        end
      end
      TRAP:    nxt = TRAP;
      default: nxt = FETCH;
    endcase
  end

  // State, sticky trap flag and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur     <= FETCH;
      illegal <= 1'b0;
      instret <= '0;
    end else begin
      cur <= nxt;
      if (nxt == TRAP) illegal <= 1'b1;
      if (PCWrite) instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as in the codebase.
REQ-002 The ports SHALL be as follows.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active high
- Op  in  7  opcode from the instruction register (IR)
- Funct7  in  7  IR funct7
- Funct3  in  3  IR funct3
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory access done (used only with MC_MEM_WAIT_EN)
- PCWrite  out  1  PC register load enable
- IRWrite  out  1  IR load enable
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register file write enable
- EXTOp  out  6  immediate-extend one-hot: J=000001, U=000010, B=000100, S=001000, I=010000
- ALUOp  out  5  NOP=0, LUI=1, AUIPC=2, ADD=3, SUB=4
- ALUSrc  out  1  ALU operand B select: 0=rs2, 1=immediate
- DMType  out  3  memory access width; equals Funct3 in MEM, 0 otherwise
- WDSel  out  2  writeback source: 00=ALU, 01=memory data register, 10=PC+4
- NPCOp  out  3  next PC: 000=PC+4, 001=branch, 010=JAL, 100=JALR
- state  out  3  current FSM state
- illegal  out  1  sticky trap flag
- instret  out  32  count of retired instructions

Function
REQ-003 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5; codes 6 and 7 SHALL go to FETCH on the next clock.
REQ-004 All outputs SHALL be Moore or Mealy combinational from state, Op, Funct3, Funct7, Zero and mem_ready; unlisted outputs SHALL be 0 or NOP.
REQ-005 FETCH SHALL drive MemRead=1 and IRWrite=1, then go to DECODE; Op is ignored in this state.
REQ-006 DECODE SHALL drive EXTOp from the opcode class.
- Legal opcodes are LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
- A legal opcode SHALL go to EXEC; any other opcode SHALL go to TRAP.
REQ-007 EXEC SHALL drive ALUOp, ALUSrc and EXTOp.
- ADD/ADDI/LOAD/STORE/JALR: ALUOp=ADD. OP with funct7=0100000: ALUOp=SUB. BRANCH: ALUOp=SUB. LUI: ALUOp=LUI. AUIPC: ALUOp=AUIPC.
- OP with funct3=000 and funct7 other than 0000000 or 0100000 SHALL drive ALUOp=NOP and SHALL still retire.
REQ-008 EXEC SHALL choose the next state by opcode.
- LOAD and STORE SHALL go to MEM.
- BRANCH SHALL assert PCWrite, with NPCOp=001 if Funct3=000 and Zero=1 and NPCOp=000 otherwise, and SHALL go to FETCH.
- All other opcodes SHALL go to WB.
REQ-009 MEM SHALL hold ALUSrc=1, ALUOp=ADD and DMType=Funct3.
- LOAD: MemRead=1, next state WB.
- STORE: MemWrite=1, PCWrite=1, NPCOp=000, next state FETCH.
REQ-010 WB SHALL assert RegWrite=1 and PCWrite=1, then go to FETCH.
- LOAD: WDSel=01.
- JAL: WDSel=10, NPCOp=010.
- JALR: WDSel=10, NPCOp=100, ALUSrc=1, ALUOp=ADD.
- Otherwise: WDSel=00, NPCOp=000.
REQ-011 Instruction latency SHALL be 3 cycles for BRANCH, 4 for STORE, OP, OP-IMM, LUI, AUIPC, JAL and JALR, and 5 for LOAD.
REQ-012 In TRAP, illegal SHALL be 1 and all enables SHALL be 0; TRAP SHALL be left only by reset.
REQ-013 instret SHALL increment by 1 on every clock edge where PCWrite=1, wrapping from 0xFFFFFFFF to 0.
REQ-014 MemRead and MemWrite SHALL never both be 1 in the same cycle, and PCWrite SHALL be 1 for at most one cycle per instruction.

Reset
REQ-015 While rst=1, state SHALL be FETCH, instret SHALL be 0 and illegal SHALL be 0, asynchronously.
REQ-016 Reset asserted mid-instruction SHALL abandon that instruction with no further PCWrite, RegWrite or MemWrite.
REQ-017 The first clock edge after reset release SHALL perform FETCH.

Configuration
REQ-018 With MC_MEM_WAIT_EN defined, FETCH and MEM SHALL hold state and their strobes while mem_ready=0.
- They SHALL advance only on mem_ready=1.
- IRWrite, PCWrite (STORE) and MemWrite SHALL have effect only in the cycle with mem_ready=1.
REQ-019 Without MC_MEM_WAIT_EN, mem_ready SHALL be ignored and FETCH and MEM SHALL each last exactly one cycle.

Verification
REQ-020 Reset, then Op=0110011, Funct7=0100000, Funct3=000 -> states 0,1,2,4,0; ALUOp=4 in EXEC; RegWrite=1 in WB only; instret=1.
REQ-021 Op=0000011, Funct3=010 -> states 0,1,2,3,4; MemRead=1 with DMType=010 in MEM; WDSel=01 in WB; 5 cycles.
REQ-022 Op=1100011, Funct3=000: with Zero=1 -> NPCOp=001 and PCWrite=1 in EXEC; with Zero=0 -> NPCOp=000; 3 cycles each.
REQ-023 Op=1111111 -> TRAP after DECODE, illegal=1, no enables for 20 cycles; rst pulse -> state=0, illegal=0, instret=0.
REQ-024 With MC_MEM_WAIT_EN, STORE with mem_ready held 0 for 3 MEM cycles -> MemWrite=1 for 4 cycles, PCWrite only in the cycle with mem_ready=1.
REQ-025 Preload the count to 0xFFFFFFFF via force, retire one ADDI -> instret=0.
